// File: rtl/mem_access_stage_pkg.sv
// Shared constants and FSM state type for the MEM pipeline stage.
package mem_access_stage_pkg;

  localparam int unsigned DefDsize   = 32;
  localparam int unsigned DefAsize   = 5;
  localparam int unsigned DefIsize   = 32;
  localparam int unsigned DefTimeout = 255;
  localparam int unsigned WdogWidth  = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack access with upstream stall, watchdog abort,
// misalignment suppression and the MEM/WB pipeline register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DSIZE   = DefDsize,
  parameter int unsigned ASIZE   = DefAsize,
  parameter int unsigned ISIZE   = DefIsize,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] aluout_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  input  logic             memread_in,
  input  logic             memwrite_in,
  input  logic             memtoreg_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] PCOUT_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [DSIZE-1:0] dmem_addr,
  output logic [DSIZE-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             stall_out,
  output logic [DSIZE-1:0] wbdata_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic             err_out
);

  localparam logic [WdogWidth-1:0] TimeoutVal = WdogWidth'(TIMEOUT);

  mem_state_e           state_q, state_d;
  logic [WdogWidth-1:0] wdog_q, wdog_d;

  logic             misalign;
  logic             mem_op;
  logic             timeout_hit;
  logic             complete;
  logic             err_set;
  logic [DSIZE-1:0] load_data;
  logic [DSIZE-1:0] wb_sel;

  assign dmem_we    = memwrite_in;
  assign dmem_addr  = aluout_in;
  assign dmem_wdata = rdata2_in;

  always_comb begin
    misalign    = |aluout_in[1:0];
    mem_op      = (memread_in | memwrite_in) & ~misalign;
    timeout_hit = (state_q == StWait) && (wdog_q == TimeoutVal);
    complete    = mem_op & (dmem_ack | timeout_hit);
    dmem_req    = mem_op & ~rst;
    stall_out   = mem_op & ~complete & ~rst;
    // An aborted access returns zero as its load data.
    load_data   = dmem_ack ? dmem_rdata : '0;
    err_set     = ((memread_in | memwrite_in) & misalign) |
                  (mem_op & timeout_hit & ~dmem_ack);

    if (jal_in) begin
      wb_sel = DSIZE'(PCOUT_in);
    end else if (memtoreg_in & memread_in & ~memwrite_in) begin
      wb_sel = load_data;
    end else begin
      wb_sel = aluout_in;
    end

    state_d = StIdle;
    wdog_d  = '0;
    if (mem_op & ~complete) begin
      state_d = StWait;
      wdog_d  = (state_q == StIdle) ? WdogWidth'(1) : wdog_q + WdogWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wdog_q     <= '0;
      wbdata_out <= '0;
      waddr_out  <= '0;
      wen_out    <= 1'b0;
      err_out    <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      if (err_set) begin
        err_out <= 1'b1;
      end
      if (stall_out) begin
        wen_out <= 1'b0;
      end else begin
        wbdata_out <= wb_sel;
        waddr_out  <= waddr_in;
        wen_out    <= wen_in & ~(misalign & memread_in);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT=4).
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic [31:0] aluout_in;
  logic [31:0] rdata2_in;
  logic [4:0]  waddr_in;
  logic        wen_in;
  logic        memread_in;
  logic        memwrite_in;
  logic        memtoreg_in;
  logic        jal_in;
  logic [31:0] PCOUT_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_out;
  logic [31:0] wbdata_out;
  logic [4:0]  waddr_out;
  logic        wen_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(
    .DSIZE  (32),
    .ASIZE  (5),
    .ISIZE  (32),
    .TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .aluout_in  (aluout_in),
    .rdata2_in  (rdata2_in),
    .waddr_in   (waddr_in),
    .wen_in     (wen_in),
    .memread_in (memread_in),
    .memwrite_in(memwrite_in),
    .memtoreg_in(memtoreg_in),
    .jal_in     (jal_in),
    .PCOUT_in   (PCOUT_in),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .stall_out  (stall_out),
    .wbdata_out (wbdata_out),
    .waddr_out  (waddr_out),
    .wen_out    (wen_out),
    .err_out    (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    aluout_in   = '0;
    rdata2_in   = '0;
    waddr_in    = '0;
    wen_in      = 1'b0;
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
    memtoreg_in = 1'b0;
    jal_in      = 1'b0;
    PCOUT_in    = '0;
    dmem_ack    = 1'b0;
    dmem_rdata  = '0;
  endtask

  initial begin
    int n;
    nop();
    rst = 1'b1;
    tick();
    tick();
    check("rst_wbdata", wbdata_out, 32'h0);
    check("rst_waddr", 32'(waddr_out), 32'h0);
    check("rst_wen", 32'(wen_out), 32'h0);
    check("rst_err", 32'(err_out), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_stall", 32'(stall_out), 32'h0);

    // ALU pass-through
    rst       = 1'b0;
    aluout_in = 32'h1234;
    wen_in    = 1'b1;
    waddr_in  = 5'd5;
    #1;
    check("alu_req", 32'(dmem_req), 32'h0);
    check("alu_stall", 32'(stall_out), 32'h0);
    tick();
    check("alu_wbdata", wbdata_out, 32'h1234);
    check("alu_waddr", 32'(waddr_out), 32'd5);
    check("alu_wen", 32'(wen_out), 32'h1);

    // Zero-wait load
    aluout_in   = 32'h40;
    memread_in  = 1'b1;
    memtoreg_in = 1'b1;
    waddr_in    = 5'd7;
    dmem_ack    = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    #1;
    check("ld0_req", 32'(dmem_req), 32'h1);
    check("ld0_we", 32'(dmem_we), 32'h0);
    check("ld0_addr", dmem_addr, 32'h40);
    check("ld0_stall", 32'(stall_out), 32'h0);
    tick();
    check("ld0_wbdata", wbdata_out, 32'hDEADBEEF);
    check("ld0_waddr", 32'(waddr_out), 32'd7);
    check("ld0_wen", 32'(wen_out), 32'h1);

    // Store acked after three stall cycles
    nop();
    aluout_in   = 32'h80;
    rdata2_in   = 32'hA5A5A5A5;
    memwrite_in = 1'b1;
    waddr_in    = 5'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("st_stall", 32'(stall_out), 32'h1);
      check("st_we", 32'(dmem_we), 32'h1);
      check("st_req", 32'(dmem_req), 32'h1);
      check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
      tick();
      check("st_bubble_wen", 32'(wen_out), 32'h0);
      check("st_hold_wbdata", wbdata_out, 32'hDEADBEEF);
      check("st_hold_waddr", 32'(waddr_out), 32'd7);
    end
    dmem_ack = 1'b1;
    #1;
    check("st_ack_stall", 32'(stall_out), 32'h0);
    check("st_ack_we", 32'(dmem_we), 32'h1);
    tick();
    check("st_wbdata", wbdata_out, 32'h80);
    check("st_waddr", 32'(waddr_out), 32'd3);
    check("st_err", 32'(err_out), 32'h0);

    // Load that never gets acked: watchdog abort
    nop();
    aluout_in   = 32'h44;
    memread_in  = 1'b1;
    memtoreg_in = 1'b1;
    wen_in      = 1'b1;
    waddr_in    = 5'd9;
    dmem_rdata  = 32'h12345678;
    #1;
    n = 0;
    while (stall_out === 1'b1 && n < 10) begin
      tick();
      check("to_bubble_wen", 32'(wen_out), 32'h0);
      n++;
    end
    check("to_stall_cycles", 32'(n), 32'd4);
    check("to_abort_stall", 32'(stall_out), 32'h0);
    tick();
    check("to_wbdata", wbdata_out, 32'h0);
    check("to_wen", 32'(wen_out), 32'h1);
    check("to_err", 32'(err_out), 32'h1);
    nop();
    tick();
    check("to_err_sticky", 32'(err_out), 32'h1);

    // Reset clears the sticky error
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_err", 32'(err_out), 32'h0);

    // Misaligned load
    aluout_in   = 32'h42;
    memread_in  = 1'b1;
    memtoreg_in = 1'b1;
    wen_in      = 1'b1;
    waddr_in    = 5'd4;
    #1;
    check("mis_req", 32'(dmem_req), 32'h0);
    check("mis_stall", 32'(stall_out), 32'h0);
    tick();
    check("mis_wen", 32'(wen_out), 32'h0);
    check("mis_err", 32'(err_out), 32'h1);

    // jal write-back
    nop();
    jal_in    = 1'b1;
    PCOUT_in  = 32'h100;
    aluout_in = 32'h55;
    wen_in    = 1'b1;
    waddr_in  = 5'd31;
    tick();
    check("jal_wbdata", wbdata_out, 32'h100);
    check("jal_waddr", 32'(waddr_out), 32'd31);
    check("jal_wen", 32'(wen_out), 32'h1);

    // Reset during WAIT
    nop();
    aluout_in  = 32'h48;
    memread_in = 1'b1;
    wen_in     = 1'b1;
    #1;
    check("rw_stall_pre", 32'(stall_out), 32'h1);
    tick();
    check("rw_stall_wait", 32'(stall_out), 32'h1);
    rst = 1'b1;
    #1;
    check("rw_req_rst", 32'(dmem_req), 32'h0);
    check("rw_stall_rst", 32'(stall_out), 32'h0);
    tick();
    check("rw_stall", 32'(stall_out), 32'h0);
    check("rw_req", 32'(dmem_req), 32'h0);
    check("rw_wen", 32'(wen_out), 32'h0);
    check("rw_err", 32'(err_out), 32'h0);
    // Back in IDLE: a same-cycle ack completes without stalling
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE0001;
    memtoreg_in = 1'b1;
    #1;
    check("rw_idle_stall", 32'(stall_out), 32'h0);
    tick();
    check("rw_idle_wbdata", wbdata_out, 32'hCAFE0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
